// File: rtl/svreal_mul_mod_if.sv
// Operand/result bundle for svreal_mul_mod: the driver uses master and the multiplier uses slave.
interface svreal_mul_mod_if #(
    parameter int a_width = 16,
    parameter int b_width = 17,
    parameter int c_width = 18
);
    logic                      cke;
    logic                      in_valid;
    logic signed [a_width-1:0] a_value;
    logic signed [b_width-1:0] b_value;
    logic signed [c_width-1:0] c_value;
    logic                      out_valid;

    modport master (
        output cke, in_valid, a_value, b_value,
        input  c_value, out_valid
    );

    modport slave (
        input  cke, in_valid, a_value, b_value,
        output c_value, out_valid
    );
endinterface

// File: rtl/svreal_mul_mod.sv
// Registered fixed-point multiply: exact product, re-aligned to c's exponent,
// saturated to c_width and captured on enabled clock edges.
module svreal_mul_mod #(
    parameter int a_width    = 16,
    parameter int a_exponent = -8,
    parameter int b_width    = 17,
    parameter int b_exponent = -9,
    parameter int c_width    = 18,
    parameter int c_exponent = -10
) (
    input  logic             clk,
    input  logic             rst_n,
    svreal_mul_mod_if.slave  bus
);
    localparam int PW = a_width + b_width;
    localparam int S  = a_exponent + b_exponent - c_exponent;
    localparam int AW = (S > 0) ? PW + S : PW;

    localparam logic [c_width-1:0] MINV = c_width'(1) << (c_width - 1);
    localparam logic [c_width-1:0] MAXV = ~MINV;

    logic signed [PW-1:0]      prod_w;
    logic signed [AW-1:0]      align_w;
    logic signed [c_width-1:0] sat_w;
    logic signed [c_width-1:0] c_value_q, c_value_d;
    logic                      out_valid_q, out_valid_d;

    // Both operands are sign-extended to the full product width, so the product is exact.
    assign prod_w = PW'(bus.a_value) * PW'(bus.b_value);

    generate
        if (S > 0) begin : g_lsh
            assign align_w = {prod_w, {S{1'b0}}};
        end else if (S == 0) begin : g_pass
            assign align_w = prod_w;
        end else begin : g_rsh
            // Shifting by PW-1 or more leaves only sign bits, which is the floor result (0 or -1).
            localparam int SH = (-S >= PW) ? PW - 1 : -S;
            assign align_w = prod_w >>> SH;
        end

        if (AW > c_width) begin : g_sat
            logic [AW-c_width:0] top_w;
            logic                fits_w;
            assign top_w  = align_w[AW-1:c_width-1];
            assign fits_w = (&top_w) | ~(|top_w);
            assign sat_w  = fits_w ? align_w[c_width-1:0]
                                   : (align_w[AW-1] ? MINV : MAXV);
        end else begin : g_nosat
            assign sat_w = c_width'(align_w);
        end
    endgenerate

    always_comb begin
        c_value_d   = c_value_q;
        out_valid_d = out_valid_q;
        if (bus.cke) begin
            c_value_d   = sat_w;
            out_valid_d = bus.in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_value_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_value_q   <= c_value_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.c_value   = c_value_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_svreal_mul_mod.sv
// Bench for svreal_mul_mod: default-parameter instance (right shift) and a left-shift instance,
// checked against an arithmetic model every cycle plus literal expectations from the test plan.
module tb_svreal_mul_mod;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cke = 1'b0;
    logic vld = 1'b0;
    logic signed [15:0] a_in = '0;
    logic signed [16:0] b_in = '0;
    logic cmp_en = 1'b0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    svreal_mul_mod_if #(.a_width(16), .b_width(17), .c_width(18)) ifa ();
    svreal_mul_mod_if #(.a_width(16), .b_width(17), .c_width(18)) ifb ();

    assign ifa.cke = cke;  assign ifa.in_valid = vld;  assign ifa.a_value = a_in;  assign ifa.b_value = b_in;
    assign ifb.cke = cke;  assign ifb.in_valid = vld;  assign ifb.a_value = a_in;  assign ifb.b_value = b_in;

    svreal_mul_mod dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

    svreal_mul_mod #(
        .a_width(16), .a_exponent(-2), .b_width(17), .b_exponent(-2),
        .c_width(18), .c_exponent(-6)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    // Real-valued rule: value = a*b * 2^s, floor for s<0, then clamp to a cw-bit signed range.
    function automatic longint mdl(input longint a, input longint b, input int s, input int cw);
        longint p, v, d, mx, mn;
        p = a * b;
        if (s >= 0) begin
            v = p * (longint'(1) << s);
        end else begin
            d = longint'(1) << (-s);
            v = p / d;
            if ((p % d) != 0 && p < 0) v = v - 1;
        end
        mx = (longint'(1) << (cw - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        if (v < mn) v = mn;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        tot_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    longint exp_a = 0;
    longint exp_b = 0;
    logic   exp_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a <= 0;
            exp_b <= 0;
            exp_v <= 1'b0;
        end else if (cke) begin
            exp_a <= mdl(a_in, b_in, -7, 18);
            exp_b <= mdl(a_in, b_in, 2, 18);
            exp_v <= vld;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_c_a", longint'(ifa.c_value), exp_a);
            chk("model_c_b", longint'(ifb.c_value), exp_b);
            chk("model_vld_a", longint'(ifa.out_valid), longint'(exp_v));
            chk("model_vld_b", longint'(ifb.out_valid), longint'(exp_v));
        end
    end

    task automatic drive(input longint a, input longint b, input logic v, input logic k);
        a_in = 16'(a);
        b_in = 17'(b);
        vld  = v;
        cke  = k;
    endtask

    // Apply inputs just after a rising edge, then land mid-cycle after the next edge.
    task automatic step(input longint a, input longint b, input logic v, input logic k);
        @(posedge clk); #1;
        drive(a, b, v, k);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic longint pick_a();
        int r = $urandom_range(0, 9);
        case (r)
            0: return 32767;
            1: return -32768;
            2: return 0;
            3: return -1;
            default: return longint'($signed(16'($urandom)));
        endcase
    endfunction

    function automatic longint pick_b();
        int r = $urandom_range(0, 9);
        case (r)
            0: return 65535;
            1: return -65536;
            2: return 1;
            3: return -1;
            default: return longint'($signed(17'($urandom)));
        endcase
    endfunction

    initial begin
        #12;
        chk("reset_c_a", longint'(ifa.c_value), 0);
        chk("reset_vld_a", longint'(ifa.out_valid), 0);
        chk("reset_c_b", longint'(ifb.c_value), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        step(315, 2335, 1'b1, 1'b1);
        chk("nominal_c", longint'(ifa.c_value), 5746);
        chk("nominal_vld", longint'(ifa.out_valid), 1);
        step(-315, 2335, 1'b1, 1'b1);
        chk("floor_neg", longint'(ifa.c_value), -5747);
        step(1, 1, 1'b1, 1'b1);
        chk("floor_tiny_pos", longint'(ifa.c_value), 0);
        step(-1, 1, 1'b1, 1'b1);
        chk("floor_tiny_neg", longint'(ifa.c_value), -1);
        step(32767, 65535, 1'b1, 1'b1);
        chk("sat_pos", longint'(ifa.c_value), 131071);
        step(-32768, 65535, 1'b1, 1'b1);
        chk("sat_neg", longint'(ifa.c_value), -131072);
        step(-32768, -65536, 1'b1, 1'b1);
        chk("sat_negneg", longint'(ifa.c_value), 131071);
        step(3, 5, 1'b1, 1'b1);
        chk("left_shift", longint'(ifb.c_value), 60);
        step(100, 200, 1'b1, 1'b0);
        chk("cke_hold_c", longint'(ifb.c_value), 60);
        chk("cke_hold_vld", longint'(ifb.out_valid), 1);
        step(315, 2335, 1'b0, 1'b1);
        chk("invalid_vld", longint'(ifa.out_valid), 0);
        chk("invalid_c", longint'(ifa.c_value), 5746);

        step(315, 2335, 1'b1, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_c", longint'(ifa.c_value), 0);
        chk("async_rst_vld", longint'(ifa.out_valid), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        drive(-315, 2335, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_c", longint'(ifa.c_value), -5747);
        chk("post_rst_vld", longint'(ifa.out_valid), 1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            drive(pick_a(), pick_b(), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
        end
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
